// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes/InvSubBytes engine: LANES S-box lookups per cycle, 16/LANES beats per block.
// Define SUBBYTES_INV_EN to build the inverse S-box and honour inv_i; otherwise the forward S-box is always used.

module sub_bytes_sbox (
  input  logic [7:0] din_i,
  input  logic       inv_i,
  output logic [7:0] dout_o
);
  // FIPS-197 forward S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
`ifdef SUBBYTES_INV_EN
  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign dout_o = inv_i ? INV[din_i] : FWD[din_i];
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign dout_o     = FWD[din_i];
`endif
endmodule

module sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  input  logic         inv_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o
);
  localparam int BEATS = 16 / LANES;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = LANES * 8;
  localparam int SH    = $clog2(CW);
  localparam logic [KW:0]   BEATS_C = (KW+1)'(BEATS);
  localparam logic [KW-1:0] LAST_K  = KW'(BEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d, sel_k;
  logic [127:0]            work_q, work_d;
  logic                    inv_q;
  logic [6:0]              base;
  logic [LANES-1:0][7:0]   chunk, sub;

  // Counter values past the last beat (only possible for LANES=16) fall back to chunk 0.
  always_comb begin
    sel_k = ({1'b0, k_q} < BEATS_C) ? k_q : '0;
    base  = 7'(sel_k) << SH;
    chunk = work_q[base +: CW];
  end

  sub_bytes_sbox u_sbox [LANES-1:0] (
    .din_i  (chunk),
    .inv_i  (inv_q),
    .dout_o (sub)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    work_d  = work_q;
    if (flush_i) begin
      state_d = IDLE;
      k_d     = '0;
      work_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          work_d  = in_data_i;
          k_d     = '0;
          state_d = RUN;
        end
        RUN: begin
          work_d[base +: CW] = sub;
          if (k_q == LAST_K) begin
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        DONE: if (out_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      work_q  <= work_d;
    end
  end

`ifdef SUBBYTES_INV_EN
  logic inv_d;
  always_comb begin
    inv_d = inv_q;
    if (!flush_i && state_q == IDLE && in_valid_i) inv_d = inv_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
`else
  logic unused_inv_i;
  assign unused_inv_i = inv_i;
  assign inv_q        = 1'b0;
`endif

  // Ready is masked by reset so it reads 0 while rst_n is held low.
  assign in_ready_o  = rst_n & (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign out_data_o  = work_q;
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench: five engines (LANES 1,2,4,8,16) share stimulus; per-engine monitors check data and latency.
module tb_sub_bytes_iter;
  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, inv = 1'b0, out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic [4:0]   rdy, ov, busy;
  logic [127:0] od [5];
  int           total = 0, bad = 0, cyc = 0;
  int           consumed [5];
  int           expected_n [5];

  typedef struct {
    logic [127:0] data;
    int           acc;
    logic [4:0]   mask;
  } exp_t;
  exp_t exp_q [$];

`ifdef SUBBYTES_INV_EN
  localparam logic [127:0] INV_EXP = {4{32'hff530100}};
`else
  localparam logic [127:0] INV_EXP = {4{32'h475510fb}};
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  for (genvar j = 0; j < 5; j++) begin : g_dut
    localparam int L  = 1 << j;
    localparam int NB = 16 / L;

    sub_bytes_iter #(.LANES(L)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (rdy[j]),
      .in_data_i   (in_data),
      .inv_i       (inv),
      .out_valid_o (ov[j]),
      .out_ready_i (out_ready),
      .out_data_o  (od[j]),
      .busy_o      (busy[j])
    );

    initial begin : mon
      int idx;
      bit prev;
      idx  = 0;
      prev = 1'b0;
      forever begin
        @(negedge clk);
        if (ov[j] && !prev) begin
          while (idx < exp_q.size() && !exp_q[idx].mask[j]) idx++;
          if (idx >= exp_q.size()) begin
            chk(1'b0, $sformatf("unexpected_out_l%0d", L), od[j], '0);
          end else begin
            chk(od[j] === exp_q[idx].data, $sformatf("data_l%0d_blk%0d", L, idx), od[j], exp_q[idx].data);
            chk((cyc - exp_q[idx].acc) == NB, $sformatf("latency_l%0d_blk%0d", L, idx),
                128'(cyc - exp_q[idx].acc), 128'(NB));
            consumed[j]++;
            idx++;
          end
        end
        prev = ov[j];
      end
    end
  end

  task automatic push_exp(input logic [127:0] e, input int acc, input logic [4:0] m);
    exp_t x;
    x.data = e;
    x.acc  = acc;
    x.mask = m;
    exp_q.push_back(x);
    for (int j = 0; j < 5; j++) if (m[j]) expected_n[j]++;
  endtask

  // Offer a block only when every engine is idle so all accept on the same edge.
  task automatic send(input logic [127:0] d, input bit iv, input logic [127:0] e,
                      input logic [4:0] m, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy !== 5'h1f && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rdy !== 5'h1f) begin
      chk(1'b0, {nm, "_accept_timeout"}, 128'(rdy), 128'h1f);
      return;
    end
    in_data  = d;
    inv      = iv;
    in_valid = 1'b1;
    push_exp(e, cyc + 1, m);
    @(negedge clk);
    in_valid = 1'b0;
    inv      = ~iv;
    in_data  = ~d;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 5'h0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(busy === 5'h0, {nm, "_idle_timeout"}, 128'(busy), '0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : drive
    int n;
    for (int j = 0; j < 5; j++) begin
      consumed[j]   = 0;
      expected_n[j] = 0;
    end

    repeat (3) @(negedge clk);
    chk(rdy === 5'h0, "rst_in_ready", 128'(rdy), '0);
    chk(ov === 5'h0, "rst_out_valid", 128'(ov), '0);
    chk(busy === 5'h0, "rst_busy", 128'(busy), '0);
    for (int j = 0; j < 5; j++) chk(od[j] === '0, $sformatf("rst_out_data_%0d", j), od[j], '0);
    rst_n = 1'b1;
    #1;
    chk(rdy === 5'h1f, "post_rst_ready", 128'(rdy), 128'h1f);

    send('0, 1'b0, {16{8'h63}}, 5'h1f, "zero");
    send({4{32'hff530100}}, 1'b0, {4{32'h16ed7c63}}, 5'h1f, "pattern");
    send({4{32'h16ed7c63}}, 1'b1, INV_EXP, 5'h1f, "inverse");
    send({4{32'h16ed7c63}}, 1'b0, {4{32'h475510fb}}, 5'h1f, "fwd_after_inv");

    // Back-pressure: result held, pending block refused until the handshake completes.
    wait_idle("bp_pre");
    out_ready = 1'b0;
    send({16{8'h53}}, 1'b0, {16{8'hed}}, 5'h1f, "bp_first");
    n = 0;
    while (ov !== 5'h1f && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(ov === 5'h1f, "bp_all_valid", 128'(ov), 128'h1f);
    in_data  = {16{8'hff}};
    inv      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk(od[2] === {16{8'hed}}, "bp_hold_data", od[2], {16{8'hed}});
      chk(ov === 5'h1f, "bp_hold_valid", 128'(ov), 128'h1f);
      chk(rdy === 5'h0, "bp_no_ready", 128'(rdy), '0);
    end
    push_exp({16{8'h16}}, cyc + 2, 5'h1f);
    out_ready = 1'b1;
    @(negedge clk);
    chk(rdy === 5'h1f, "bp_idle_ready", 128'(rdy), 128'h1f);
    @(negedge clk);
    chk(busy === 5'h1f, "bp_pending_accepted", 128'(busy), 128'h1f);
    in_valid = 1'b0;

    // Flush at k=2 of the LANES=4 engine; only LANES=8/16 finish first.
    wait_idle("flush_pre");
    send({16{8'h53}}, 1'b0, {16{8'hed}}, 5'b11000, "flush_blk");
    @(negedge clk);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = {16{8'haa}};
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk(busy === 5'h0, "flush_idle", 128'(busy), '0);
    chk(ov === 5'h0, "flush_valid", 128'(ov), '0);
    chk(rdy === 5'h1f, "flush_ready", 128'(rdy), 128'h1f);
    for (int j = 0; j < 5; j++) chk(od[j] === '0, $sformatf("flush_data_%0d", j), od[j], '0);
    send({16{8'h01}}, 1'b0, {16{8'h7c}}, 5'h1f, "post_flush");

    // Asynchronous reset mid-RUN; only LANES=16 has already produced its result.
    wait_idle("rst_pre");
    send({4{32'hff530100}}, 1'b0, {4{32'h16ed7c63}}, 5'b10000, "rst_blk");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(ov === 5'h0, "midrst_valid", 128'(ov), '0);
    chk(busy === 5'h0, "midrst_busy", 128'(busy), '0);
    chk(rdy === 5'h0, "midrst_ready", 128'(rdy), '0);
    for (int j = 0; j < 5; j++) chk(od[j] === '0, $sformatf("midrst_data_%0d", j), od[j], '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send({16{8'hff}}, 1'b0, {16{8'h16}}, 5'h1f, "post_rst");
    wait_idle("final");
    @(negedge clk);

    for (int j = 0; j < 5; j++)
      chk(consumed[j] == expected_n[j], $sformatf("blocks_seen_%0d", j),
          128'(consumed[j]), 128'(expected_n[j]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Parametrised, iterative AES SubBytes/InvSubBytes engine. It substitutes a 128-bit state through LANES S-box instances per cycle, taking 16/LANES cycles per block. The datapath has full valid/ready handshakes on input and output, and a synchronous flush. It sits between AddRoundKey and ShiftRows in the round datapath. It replaces the fixed 4-byte-per-cycle, enable-driven substitution stage.

## Interface
Parameters:
- LANES, 4, bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- BEATS, 16/LANES, derived localparam; not overridable.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous abort; highest priority after reset.
- in_valid_i  in  1  input block valid.
- in_ready_o  out  1  block can be accepted.
- in_data_i  in  128  state; byte i = bits [8i+7:8i].
- inv_i  in  1  1 = inverse S-box; sampled at accept.
- out_valid_o  out  1  result valid; held until accepted.
- out_ready_i  in  1  downstream accepts result.
- out_data_o  out  128  result register.
- busy_o  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i && in_ready_o: capture in_data_i into the work register, latch inv_i, clear beat counter k to 0, go to RUN.
- RUN:
  - Each cycle, bytes k*LANES .. k*LANES+LANES-1 of the work register are replaced by S(byte), or S⁻¹(byte) if the latched inv is set. All other bytes hold.
  - k increments each cycle.
  - When k == BEATS-1, that chunk is written, k wraps to 0, and the state goes to DONE.
- DONE:
  - out_valid_o=1; out_data_o is stable.
  - On out_ready_i, go to IDLE.
  - No new block is accepted in the same cycle; in_ready_o=0 outside IDLE.
- out_data_o is the work register at all times. Its contents are architecturally meaningful only while out_valid_o=1.
- flush_i=1 in any state: next state IDLE, k=0, work register cleared to 0, out_valid_o=0. Any simultaneous in_valid_i is ignored.
- The S-box is a combinational LUT (LANES instances, FIPS-197 table). The mux selects chunk k by an indexed part-select with no default holes; an unused counter value selects chunk 0.
- The counter width is max(1, $clog2(BEATS)). For LANES=16 the counter is a constant 0 and RUN lasts 1 cycle.

## Timing
- Reset values: in_ready_o=0 during reset and 1 in the first cycle after deassertion (IDLE). out_valid_o=0, out_data_o=128'h0, busy_o=0.
- Latency: if the accept edge is E0, out_valid_o rises after edge E_BEATS. This is 4 cycles for LANES=4, 16 cycles for LANES=1 and 1 cycle for LANES=16.
- Throughput: one block per BEATS+2 cycles when out_ready_i is tied high (accept cycle + RUN + DONE).
- Back-pressure: out_valid_o and out_data_o hold indefinitely while out_ready_i=0.
- Reset mid-RUN: outputs return to their reset values immediately (asynchronous); the partial block is discarded.
- inv_i changes after accept have no effect on the block in flight.

## Configuration
- SUBBYTES_INV_EN defined:
  - The inverse S-box LUTs are instantiated.
  - inv_i selects S⁻¹ per block.
- SUBBYTES_INV_EN undefined:
  - No inverse LUTs are built.
  - The inv_i port remains but is ignored; forward S-box is always used.

## Test plan
- Reset release, LANES=4, in_data=128'h0 accepted at cycle 1 → out_valid_o after 4 cycles, out_data=128'h6363…63 (16 bytes of 0x63).
- LANES in {1, 2, 8, 16}, byte pattern 0x00,0x01,0x53,0xff repeated → bytes 0x63,0x7c,0xed,0x16. Latencies must be 16, 8, 2 and 1 respectively.
- With SUBBYTES_INV_EN, inv_i=1, input bytes 0x63,0x7c,0xed,0x16 repeated → 0x00,0x01,0x53,0xff. Without the macro, the same stimulus yields the forward values 0xfb,0x10,0x55,0x47.
- out_ready_i held 0 for 10 cycles after out_valid_o → data stable, in_ready_o=0 and a pending in_valid_i is not accepted. When out_ready_i rises, the next block is accepted in the following IDLE cycle.
- flush_i pulsed when k=2 (LANES=4) → next cycle is IDLE with out_data=0. A following block of all 0x01 then completes normally with all bytes 0x7c.
- rst_n asserted during RUN → out_valid_o=0 and out_data=0 immediately. After release, the first block processes correctly.
